// File: rtl/imem_loader_pkg.sv
// Shared constants, FSM state encoding and header decode for the instruction-memory loader.
// The instruction memory itself is sized from IMEM_DEPTH.
package imem_pkg;

    localparam int IMEM_DEPTH  = 1024;
    localparam int IMEM_ADDR_W = 10;
    localparam int LEN_W       = 16;
    localparam int BYTE_W      = 8;
    localparam int WORD_W      = 32;

    typedef enum logic [2:0] {
        ST_LEN_LO = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_DATA   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    // Compare at LEN_W+1 bits so a depth of 65536 is still representable.
    function automatic state_t hdr_next_state(input logic [LEN_W-1:0] cnt,
                                              input logic [LEN_W:0]   depth);
        state_t nxt;
        if (cnt == {LEN_W{1'b0}}) begin
            nxt = ST_DONE;
        end else if ({1'b0, cnt} > depth) begin
            nxt = ST_ERR;
        end else begin
            nxt = ST_DATA;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
// slave = loader side, master = stream source / memory side.
interface imem_loader_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
);
    logic              byte_valid;
    logic [BYTE_W-1:0] byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [WORD_W-1:0] imem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer: byte k of a word lands at bits [8k+7:8k].
// word_o already contains the byte being pushed so the caller can register it on the 4th push.
module byte_packer
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_full_o
);

    logic [1:0]        idx_q;
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_d;

    // Insert the incoming byte at the current byte lane.
    always_comb begin
        word_d = word_q;
        word_d[{idx_q, 3'b000} +: BYTE_W] = byte_i;
    end

    assign word_o      = word_d;
    assign word_full_o = push_i & (idx_q == 2'd3);

    // Lane index and partial word; the index wraps to 0 after the 4th byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q  <= 2'd0;
            word_q <= {WORD_W{1'b0}};
        end else if (clr_i) begin
            idx_q  <= 2'd0;
        end else if (push_i) begin
            idx_q  <= idx_q + 2'd1;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: 16-bit LE word count header, then the image,
// written one 32-bit word at a time; holds the core in reset until the image is complete.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
)(
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus,
    output logic          core_rst_n_o,
    output logic          load_done_o,
    output logic          load_err_o
);

    localparam logic [LEN_W:0] DEPTH_L = (LEN_W+1)'(DEPTH);

    state_t            state_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W:0]    word_cnt_q;
    logic [LEN_W:0]    word_cnt_d;
    logic [LEN_W-1:0]  len_d;
    state_t            hdr_nxt_d;

    logic              byte_ready_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_waddr_q;
    logic [WORD_W-1:0] imem_wdata_q;
    logic              core_rst_n_q;
    logic              load_done_q;
    logic              load_err_q;

    logic              xfer;
    logic              push;
    logic              word_full;
    logic [WORD_W-1:0] packed_word;

    assign xfer       = bus.byte_valid & byte_ready_q;
    assign push       = xfer & (state_q == ST_DATA);
    assign len_d      = {bus.byte_data, len_q[7:0]};
    assign hdr_nxt_d  = hdr_next_state(len_d, DEPTH_L);
    assign word_cnt_d = word_cnt_q + {{LEN_W{1'b0}}, 1'b1};

    byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (state_q != ST_DATA),
        .push_i      (push),
        .byte_i      (bus.byte_data),
        .word_o      (packed_word),
        .word_full_o (word_full)
    );

    // Loader FSM; every output is registered from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_LEN_LO;
            len_q        <= {LEN_W{1'b0}};
            word_cnt_q   <= {(LEN_W+1){1'b0}};
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= {ADDR_W{1'b0}};
            imem_wdata_q <= {WORD_W{1'b0}};
            core_rst_n_q <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_LEN_LO: begin
                    byte_ready_q <= 1'b1;
                    imem_we_q    <= 1'b0;
                    if (xfer) begin
                        len_q[7:0] <= bus.byte_data;
                        state_q    <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    imem_we_q <= 1'b0;
                    if (xfer) begin
                        len_q        <= len_d;
                        state_q      <= hdr_nxt_d;
                        byte_ready_q <= (hdr_nxt_d == ST_DATA);
                        core_rst_n_q <= (hdr_nxt_d == ST_DONE);
                        load_done_q  <= (hdr_nxt_d == ST_DONE);
                        load_err_q   <= (hdr_nxt_d == ST_ERR);
                    end else begin
                        byte_ready_q <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (word_full) begin
                        state_q      <= ST_WRITE;
                        byte_ready_q <= 1'b0;
                        imem_we_q    <= 1'b1;
                        imem_waddr_q <= word_cnt_q[ADDR_W-1:0];
                        imem_wdata_q <= packed_word;
                    end else begin
                        byte_ready_q <= 1'b1;
                        imem_we_q    <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    imem_we_q  <= 1'b0;
                    word_cnt_q <= word_cnt_d;
                    if (word_cnt_d == {1'b0, len_q}) begin
                        state_q      <= ST_DONE;
                        byte_ready_q <= 1'b0;
                        core_rst_n_q <= 1'b1;
                        load_done_q  <= 1'b1;
                    end else begin
                        state_q      <= ST_DATA;
                        byte_ready_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    byte_ready_q <= 1'b0;
                    imem_we_q    <= 1'b0;
                    core_rst_n_q <= 1'b1;
                    load_done_q  <= 1'b1;
                end
                ST_ERR: begin
                    byte_ready_q <= 1'b0;
                    imem_we_q    <= 1'b0;
                    core_rst_n_q <= 1'b0;
                    load_err_q   <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: park safely with the core held in reset.
                    state_q      <= ST_ERR;
                    byte_ready_q <= 1'b0;
                    imem_we_q    <= 1'b0;
                    core_rst_n_q <= 1'b0;
                    load_err_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_waddr = imem_waddr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign core_rst_n_o   = core_rst_n_q;
    assign load_done_o    = load_done_q;
    assign load_err_o     = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized loads
// checked against a byte-stream reference model.
module tb_imem_loader;
    import imem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic core_rst_n, load_done, load_err;

    imem_loader_if #(.ADDR_W(IMEM_ADDR_W)) bus();

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .core_rst_n_o (core_rst_n),
        .load_done_o  (load_done),
        .load_err_o   (load_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]             stream_q[$];
    logic [IMEM_ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]            wr_data_q[$];
    logic [IMEM_ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]            exp_data_q[$];
    bit                     exp_err;
    bit                     prev_we = 1'b0;
    bit                     chk_ready = 1'b0;

    // Write monitor and per-cycle protocol checks, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.imem_we === 1'b1) begin
                wr_addr_q.push_back(bus.imem_waddr);
                wr_data_q.push_back(bus.imem_wdata);
                n_cmp++;
                if (prev_we) begin
                    n_err++;
                    $display("FAIL we_width: imem_we high for 2 cycles at addr %0d, required 1 cycle", bus.imem_waddr);
                end
            end
            prev_we = (bus.imem_we === 1'b1);
            if (chk_ready && load_done !== 1'b1) begin
                n_cmp++;
                if (bus.byte_ready !== !bus.imem_we) begin
                    n_err++;
                    $display("FAIL ready_vs_write: byte_ready=%b imem_we=%b, required byte_ready low only in write cycle",
                             bus.byte_ready, bus.imem_we);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: header is a LE 16-bit count, then 4 LE bytes per word at consecutive addresses.
    task automatic model_build();
        int cnt;
        exp_addr_q.delete();
        exp_data_q.delete();
        cnt = int'(stream_q[0]) + 256 * int'(stream_q[1]);
        exp_err = (cnt > IMEM_DEPTH);
        if (!exp_err) begin
            for (int w = 0; w < cnt; w++) begin
                exp_addr_q.push_back(IMEM_ADDR_W'(w));
                exp_data_q.push_back(32'(stream_q[2+4*w])
                                   + 32'(stream_q[3+4*w]) * 32'd256
                                   + 32'(stream_q[4+4*w]) * 32'd65536
                                   + 32'(stream_q[5+4*w]) * 32'd16777216);
            end
        end
    endtask

    task automatic apply_reset();
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
        prev_we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int  gap;
        int  t;
        bit  ok;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        t  = 0;
        ok = 1'b0;
        while (!ok && t < 200) begin
            @(negedge clk);
            ok = (bus.byte_ready === 1'b1);
            @(posedge clk); #1;
            t++;
        end
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'($urandom_range(255, 0));
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL handshake_timeout: byte %h not accepted in 200 cycles, required acceptance", b);
        end
    endtask

    task automatic send_stream(input int max_gap);
        foreach (stream_q[i]) send_byte(stream_q[i], max_gap);
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.byte_ready, bus.imem_we, bus.imem_waddr, bus.imem_wdata, core_rst_n, load_done, load_err} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: rdy=%b we=%b addr=%h data=%h crst=%b done=%b err=%b, required all 0",
                     bus.byte_ready, bus.imem_we, bus.imem_waddr, bus.imem_wdata, core_rst_n, load_done, load_err);
        end
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.byte_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ready_before_edge: byte_ready=%b, required 0", bus.byte_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.byte_ready !== 1'b1 || core_rst_n !== 1'b0 || load_done !== 1'b0) begin
            n_err++;
            $display("FAIL ready_after_release: rdy=%b crst=%b done=%b, required 1 0 0", bus.byte_ready, core_rst_n, load_done);
        end
    endtask

    task automatic test_normal();
        logic [31:0] exp_w[3];
        exp_w[0] = 32'h00500293;
        exp_w[1] = 32'h00300313;
        exp_w[2] = 32'h006283B3;
        apply_reset();
        stream_q = '{8'h03, 8'h00, 8'h93, 8'h02, 8'h50, 8'h00, 8'h13, 8'h03,
                     8'h30, 8'h00, 8'hB3, 8'h83, 8'h62, 8'h00};
        send_stream(0);
        @(negedge clk);
        n_cmp++;
        if (bus.imem_we !== 1'b1 || bus.imem_waddr !== 10'd2 || load_done !== 1'b0) begin
            n_err++;
            $display("FAIL normal_last_write: we=%b addr=%0d done=%b, required 1 2 0", bus.imem_we, bus.imem_waddr, load_done);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.imem_we !== 1'b0 || load_done !== 1'b1 || core_rst_n !== 1'b1) begin
            n_err++;
            $display("FAIL normal_done: we=%b done=%b crst=%b, required 0 1 1", bus.imem_we, load_done, core_rst_n);
        end
        n_cmp++;
        if (wr_addr_q.size() != 3) begin
            n_err++;
            $display("FAIL normal_count: %0d writes, required 3", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (wr_addr_q[i] !== IMEM_ADDR_W'(i) || wr_data_q[i] !== exp_w[i]) begin
                    n_err++;
                    $display("FAIL normal_word%0d: addr=%0d data=%h, required addr=%0d data=%h",
                             i, wr_addr_q[i], wr_data_q[i], i, exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_zero_count();
        apply_reset();
        stream_q = '{8'h00, 8'h00};
        send_stream(0);
        @(negedge clk);
        n_cmp++;
        if (load_done !== 1'b1 || core_rst_n !== 1'b1 || load_err !== 1'b0 || bus.byte_ready !== 1'b0) begin
            n_err++;
            $display("FAIL zero_done: done=%b crst=%b err=%b rdy=%b, required 1 1 0 0",
                     load_done, core_rst_n, load_err, bus.byte_ready);
        end
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.byte_data = 8'($urandom_range(255, 0));
            @(negedge clk);
            n_cmp++;
            if (bus.byte_ready !== 1'b0) begin
                n_err++;
                $display("FAIL zero_ignore: byte_ready=%b after done, required 0", bus.byte_ready);
            end
            @(posedge clk); #1;
        end
        bus.byte_valid = 1'b0;
        n_cmp++;
        if (wr_addr_q.size() != 0 || load_done !== 1'b1) begin
            n_err++;
            $display("FAIL zero_nowrite: %0d writes done=%b, required 0 writes done=1", wr_addr_q.size(), load_done);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        stream_q = '{8'h01, 8'h04};
        send_stream(0);
        bus.byte_valid = 1'b1;
        repeat (4) @(negedge clk);
        bus.byte_valid = 1'b0;
        n_cmp++;
        if (load_err !== 1'b1 || core_rst_n !== 1'b0 || bus.byte_ready !== 1'b0 || load_done !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_state: err=%b crst=%b rdy=%b done=%b, required 1 0 0 0",
                     load_err, core_rst_n, bus.byte_ready, load_done);
        end
        n_cmp++;
        if (wr_addr_q.size() != 0) begin
            n_err++;
            $display("FAIL overflow_nowrite: %0d writes, required 0", wr_addr_q.size());
        end
    endtask

    task automatic test_boundary();
        int bad;
        apply_reset();
        stream_q = '{8'h00, 8'h04};
        for (int i = 0; i < 4096; i++) stream_q.push_back(8'($urandom_range(255, 0)));
        model_build();
        send_stream(0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wr_addr_q.size() != exp_addr_q.size()) begin
            n_err++;
            $display("FAIL boundary_count: %0d writes, required %0d", wr_addr_q.size(), exp_addr_q.size());
        end else begin
            bad = 0;
            for (int i = 0; i < exp_addr_q.size(); i++) begin
                n_cmp++;
                if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
                    n_err++;
                    if (bad < 4)
                        $display("FAIL boundary_word%0d: addr=%0d data=%h, required addr=%0d data=%h",
                                 i, wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
                    bad++;
                end
            end
            n_cmp++;
            if (wr_addr_q[1023] !== 10'd1023) begin
                n_err++;
                $display("FAIL boundary_last_addr: %0d, required 1023", wr_addr_q[1023]);
            end
        end
        n_cmp++;
        if (load_done !== 1'b1 || core_rst_n !== 1'b1 || load_err !== 1'b0) begin
            n_err++;
            $display("FAIL boundary_done: done=%b crst=%b err=%b, required 1 1 0", load_done, core_rst_n, load_err);
        end
    endtask

    task automatic test_gapped();
        apply_reset();
        chk_ready = 1'b1;
        stream_q = '{8'h01, 8'h00, 8'h03, 8'h24, 8'h00, 8'h00};
        send_stream(5);
        @(negedge clk);
        n_cmp++;
        if (bus.imem_we !== 1'b1 || bus.byte_ready !== 1'b0 || bus.imem_waddr !== 10'd0 || bus.imem_wdata !== 32'h00002403) begin
            n_err++;
            $display("FAIL gapped_write: we=%b rdy=%b addr=%0d data=%h, required 1 0 0 00002403",
                     bus.imem_we, bus.byte_ready, bus.imem_waddr, bus.imem_wdata);
        end
        @(negedge clk);
        chk_ready = 1'b0;
        n_cmp++;
        if (load_done !== 1'b1 || bus.byte_ready !== 1'b0 || wr_addr_q.size() != 1) begin
            n_err++;
            $display("FAIL gapped_done: done=%b rdy=%b writes=%0d, required 1 0 1", load_done, bus.byte_ready, wr_addr_q.size());
        end
    endtask

    task automatic test_random();
        int cnt;
        int gap;
        for (int it = 0; it < 8; it++) begin
            apply_reset();
            chk_ready = 1'b1;
            cnt = int'($urandom_range(6, 1));
            gap = int'($urandom_range(3, 0));
            stream_q = '{8'(cnt), 8'h00};
            for (int i = 0; i < 4 * cnt; i++) stream_q.push_back(8'($urandom_range(255, 0)));
            model_build();
            send_stream(gap);
            repeat (3) @(negedge clk);
            chk_ready = 1'b0;
            n_cmp++;
            if (wr_addr_q.size() != exp_addr_q.size() || load_done !== 1'b1 || core_rst_n !== 1'b1) begin
                n_err++;
                $display("FAIL random%0d_end: writes=%0d done=%b crst=%b, required %0d 1 1",
                         it, wr_addr_q.size(), load_done, core_rst_n, exp_addr_q.size());
            end else begin
                for (int i = 0; i < exp_addr_q.size(); i++) begin
                    n_cmp++;
                    if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
                        n_err++;
                        $display("FAIL random%0d_word%0d: addr=%0d data=%h, required addr=%0d data=%h",
                                 it, i, wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h55, 0);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.byte_ready, bus.imem_we, bus.imem_waddr, bus.imem_wdata, core_rst_n, load_done, load_err} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: rdy=%b we=%b addr=%h data=%h crst=%b done=%b err=%b, required all 0",
                     bus.byte_ready, bus.imem_we, bus.imem_waddr, bus.imem_wdata, core_rst_n, load_done, load_err);
        end
        #3 rst = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
        @(posedge clk); #1;
        stream_q = '{8'h01, 8'h00, 8'h13, 8'h04, 8'h24, 8'h00};
        send_stream(1);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wr_addr_q.size() != 1) begin
            n_err++;
            $display("FAIL midreset_count: %0d writes, required 1", wr_addr_q.size());
        end else begin
            n_cmp++;
            if (wr_addr_q[0] !== 10'd0 || wr_data_q[0] !== 32'h00240413) begin
                n_err++;
                $display("FAIL midreset_word: addr=%0d data=%h, required addr=0 data=00240413", wr_addr_q[0], wr_data_q[0]);
            end
        end
        n_cmp++;
        if (load_done !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_done: done=%b, required 1", load_done);
        end
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        test_reset();
        test_normal();
        test_zero_count();
        test_overflow();
        test_gapped();
        test_random();
        test_reset_mid();
        test_boundary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the instruction memory.
- Accepts a byte stream over a valid/ready handshake, carrying a 16-bit word count followed by the program image.
- Assembles each group of 4 bytes, little-endian, into one 32-bit instruction and drives a single-cycle write into the instruction memory write port.
- Holds the core in reset until the full image has been written, then releases it.

Parameters:
DEPTH, 1024, number of 32-bit words in instruction memory.
ADDR_W, 10, word-address width; must equal clog2(DEPTH).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset asserted).
byte_valid  input  1  source has a byte on byte_data.
byte_data  input  8  stream byte.
byte_ready  output  1  loader can accept a byte this cycle; transfer occurs when byte_valid && byte_ready at a clock edge.
imem_we  output  1  one-cycle write strobe to instruction memory.
imem_waddr  output  ADDR_W  word address (byte address = imem_waddr<<2).
imem_wdata  output  32  assembled instruction word.
core_rst_n  output  1  active-low reset to pipeline core; 0 while loading.
load_done  output  1  sticky; image fully written.
load_err  output  1  sticky; header word count exceeds DEPTH.

Behaviour:
- Reset (rst=0, async) outputs: byte_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, core_rst_n=0, load_done=0, load_err=0. State goes to LEN_LO; byte counter and word counter cleared.
- First cycle after reset release: byte_ready=1 (registered output, asserted from state).
- State LEN_LO: accepting a byte stores it as count[7:0]; go to LEN_HI.
- State LEN_HI: accepting a byte stores it as count[15:8]; then:
  - count==0 -> DONE.
  - count>DEPTH -> ERR.
  - otherwise -> DATA.
- State DATA:
  - Each accepted byte is placed at bits [8*k+7:8*k], where k = byte index 0..3 within the word (little-endian, RISC-V order).
  - On the 4th byte, go to WRITE.
- State WRITE (exactly one cycle):
  - byte_ready=0, imem_we=1, imem_wdata=assembled word, imem_waddr=word counter.
  - Then increment the word counter and clear the byte index.
  - If word counter+1 == count -> DONE, else -> DATA.
- Write latency: imem_we is high in the cycle immediately after the edge that accepted byte 3 of a word.
- imem_we is never high outside WRITE. imem_waddr/imem_wdata hold their last values otherwise.
- Address never wraps: count<=DEPTH guarantees the last address is DEPTH-1.
- State DONE:
  - byte_ready=0, core_rst_n=1, load_done=1.
  - Held until rst. Further bytes are ignored (never accepted).
- State ERR:
  - byte_ready=0, core_rst_n=0, load_err=1.
  - Held until rst. No memory writes occur.
- Handshake rules:
  - byte_valid may drop between bytes with any gap; state is held.
  - byte_data is sampled only on a transfer.
  - byte_ready does not depend combinationally on byte_valid.
- Reset mid-load: async reset aborts immediately. Words already written stay in memory; the next load restarts from the header and address 0.
- Width rule: count compare is done at 17 bits, so DEPTH=65536 is representable.

Decomposition:
- Shared package (imem_pkg): IMEM_DEPTH=1024, IMEM_ADDR_W=10, the state encoding enum (LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR), and LEN_W=16. The instruction memory uses the same depth constant.
- One natural sub-module, byte_packer: 2-bit byte index plus 32-bit shift/insert register, with a word_full flag. The FSM and counters stay in imem_loader.

Test Plan:
- Normal load: bytes 03 00, then 93 02 50 00, 13 03 30 00, B3 83 62 00 -> three writes:
  - addr0=0x00500293, addr1=0x00300313, addr2=0x006283B3.
  - Each imem_we is one cycle wide.
  - load_done=1 and core_rst_n=1 in the cycle after the third write.
- Zero count: bytes 00 00 -> no imem_we; load_done=1, core_rst_n=1; later byte_valid pulses see byte_ready=0.
- Overflow: bytes 01 04 (count=1025) -> load_err=1, core_rst_n=0, byte_ready=0, no writes. Boundary: count=1024 (00 04) with 4096 bytes -> last write at addr 1023, then done.
- Gapped/backpressure: count=1, byte_valid toggling with 0-5 idle cycles between bytes 03 24 00 00 -> single write addr0=0x00002403. byte_ready=0 exactly in the WRITE cycle.
- Reset mid-DATA: after 2 data bytes of the first word, pulse rst=0 asynchronously (not aligned to clk):
  - All outputs reset immediately.
  - A subsequent full stream 01 00 13 04 24 00 writes addr0=0x00240413 only.
